// File: rtl/sdlib_pkg.sv
// Shared helpers for the sd FIFO head/tail blocks: pointer width and
// wrap-bit pointer arithmetic on 32-bit carriers, truncated by the caller.
package sdlib_pkg;

    localparam int PF_ENTRIES = 2;

    function automatic int log2c(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] ptr_mask(input int asz);
        return (32'd1 << (asz + 1)) - 32'd1;
    endfunction

    // Pointers carry one extra wrap bit, so they count modulo 2*depth.
    function automatic logic [31:0] ptr_inc(input logic [31:0] p, input int asz);
        return (p + 32'd1) & ptr_mask(asz);
    endfunction

    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                             input int asz);
        return (a - b) & ptr_mask(asz);
    endfunction

    function automatic logic ptr_eq(input logic [31:0] a, input logic [31:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/sd_pf_buf.sv
// Two-entry prefetch buffer; slot 0 is always the oldest entry so dout is
// taken straight from a register.
module sd_pf_buf
    import sdlib_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic [1:0]       cnt
);

    logic [width-1:0] s0_q, s0_d;
    logic [width-1:0] s1_q, s1_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        s0_d  = s0_q;
        s1_d  = s1_q;
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) s0_d = din;
                else               s1_d = din;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                s0_d  = s1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous capture and pop: count stays, queue shifts.
                if (cnt_q == 2'd1) begin
                    s0_d = din;
                end else begin
                    s0_d = s1_q;
                    s1_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_q  <= '0;
            s1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            s0_q  <= s0_d;
            s1_q  <= s1_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = s0_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/sd_fifo_tail_pf.sv
// FIFO tail with a 2-entry prefetch in front of a synchronous-read RAM.
// Optional registered occupancy output under SD_TAIL_PF_USAGE_EN.
module sd_fifo_tail_pf
    import sdlib_pkg::*;
#(
    parameter  int width = 8,
    parameter  int depth = 16,
    localparam int asz   = log2c(depth)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [asz:0]     wrptr_head,
    output logic [asz:0]     rdptr_tail,
    output logic             rd_en,
    output logic [asz-1:0]   rd_addr,
    input  logic [width-1:0] mem_rddata,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [width-1:0] p_data
`ifdef SD_TAIL_PF_USAGE_EN
   ,output logic [asz+1:0]   p_usage
`endif
);

    localparam int PW = asz + 1;

    logic [asz:0] iptr_q, iptr_d;
    logic [asz:0] rdptr_q, rdptr_d;
    logic         inflight_q, inflight_d;
    logic [1:0]   bcnt;
    logic         pop;
    logic [2:0]   committed_use;
    logic         rd_en_c;

    // Issue only while buffer plus outstanding reads leave a free slot.
    always_comb begin
        pop           = p_srdy & p_drdy;
        committed_use = {1'b0, bcnt} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en_c       = reset_n
                      & ~ptr_eq(32'(wrptr_head), 32'(iptr_q))
                      & (committed_use < 3'(PF_ENTRIES));
        iptr_d        = rd_en_c ? PW'(ptr_inc(32'(iptr_q), asz)) : iptr_q;
        rdptr_d       = inflight_q ? PW'(ptr_inc(32'(rdptr_q), asz)) : rdptr_q;
        inflight_d    = rd_en_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iptr_q     <= '0;
            rdptr_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            iptr_q     <= iptr_d;
            rdptr_q    <= rdptr_d;
            inflight_q <= inflight_d;
        end
    end

    sd_pf_buf #(
        .width (width)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (inflight_q),
        .pop     (pop),
        .din     (mem_rddata),
        .dout    (p_data),
        .cnt     (bcnt)
    );

    assign rd_en      = rd_en_c;
    assign rd_addr    = iptr_q[asz-1:0];
    assign rdptr_tail = rdptr_q;
    assign p_srdy     = (bcnt != 2'd0);

`ifdef SD_TAIL_PF_USAGE_EN
    logic [asz+1:0] usage_q, usage_d;

    always_comb begin
        usage_d = (asz+2)'(ptr_diff(32'(wrptr_head), 32'(rdptr_q), asz))
                + {{asz{1'b0}}, bcnt};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) usage_q <= '0;
        else          usage_q <= usage_d;
    end

    assign p_usage = usage_q;
`endif

endmodule
